// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the boot loader / memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        ST_BOOT,
        ST_RUN
    } state_t;

    typedef enum logic [1:0] {
        G_NONE,
        G_IF,
        G_DM
    } gnt_tag_t;

    localparam int WORD_BYTES = 4;
    localparam int WORD_LSB   = $clog2(WORD_BYTES);

endpackage

// File: rtl/mem_boot_arbiter_if.sv
// Bundle of host boot stream, fetch port, data port and memory array signals.
interface mem_boot_arbiter_if import mem_arb_pkg::*; #(
    parameter int ADDR_W = 12
);
    logic                      boot_valid;
    logic [8*WORD_BYTES-1:0]   boot_data;
    logic                      boot_last;
    logic                      boot_ready;
    logic                      boot_done;
    logic                      boot_err;
    logic                      cpu_stall;

    logic                      if_req;
    logic [ADDR_W-1:0]         if_addr;
    logic                      if_gnt;
    logic                      if_rvalid;
    logic [8*WORD_BYTES-1:0]   if_rdata;

    logic                      dm_req;
    logic                      dm_we;
    logic [WORD_BYTES-1:0]     dm_be;
    logic [ADDR_W-1:0]         dm_addr;
    logic [8*WORD_BYTES-1:0]   dm_wdata;
    logic                      dm_gnt;
    logic                      dm_rvalid;
    logic [8*WORD_BYTES-1:0]   dm_rdata;

    logic                      mem_en;
    logic [WORD_BYTES-1:0]     mem_we;
    logic [ADDR_W-3:0]         mem_addr;
    logic [8*WORD_BYTES-1:0]   mem_wdata;
    logic [8*WORD_BYTES-1:0]   mem_rdata;

    // Arbiter side
    modport slave (
        input  boot_valid, boot_data, boot_last,
        output boot_ready, boot_done, boot_err, cpu_stall,
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Host, pipeline and memory array side
    modport master (
        output boot_valid, boot_data, boot_last,
        input  boot_ready, boot_done, boot_err, cpu_stall,
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_grant_sel.sv
// Per-cycle grant select between fetch and data ports.
// MEM_ARB_RR_EN selects round-robin on contention; otherwise data port has fixed priority.
module mem_grant_sel (
`ifdef MEM_ARB_RR_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic en,
    input  logic if_req,
    input  logic dm_req,
    output logic if_gnt,
    output logic dm_gnt
);

`ifdef MEM_ARB_RR_EN
    // Cleared on reset to "fetch went last", so the data port wins the first tie.
    logic last_dm_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dm_p1 <= 1'b0;
        end else if (if_gnt || dm_gnt) begin
            last_dm_p1 <= dm_gnt;
        end
    end

    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (en) begin
            if (if_req && dm_req) begin
                dm_gnt = !last_dm_p1;
                if_gnt = last_dm_p1;
            end else begin
                dm_gnt = dm_req;
                if_gnt = if_req;
            end
        end
    end
`else
    always_comb begin
        dm_gnt = en && dm_req;
        if_gnt = en && if_req && !dm_req;
    end
`endif

endmodule

// File: rtl/mem_boot_arbiter.sv
// Boot loader and single-port memory arbiter between IF fetch and MEM load/store.
// Optional macro MEM_ARB_RR_EN: round-robin arbitration instead of data-first priority.
module mem_boot_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_W     = 12,
    parameter int BOOT_WORDS = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_boot_arbiter_if.slave  bus
);

    localparam int                WA_W     = ADDR_W - WORD_LSB;
    localparam logic [WA_W-1:0]   LAST_IDX = WA_W'(BOOT_WORDS - 1);

    state_t            state_q, state_d;
    logic [WA_W-1:0]   count_q, count_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              boot_wr;
    logic              run;
    logic              if_gnt, dm_gnt;
    gnt_tag_t          gnt_tag_d, gnt_tag_p1;
    logic [31:0]       if_rdata_p1, dm_rdata_p1;
    logic              unused_addr_lsbs;

    assign unused_addr_lsbs = ^{bus.if_addr[WORD_LSB-1:0], bus.dm_addr[WORD_LSB-1:0]};
    assign run = (state_q == ST_RUN);

    mem_grant_sel u_grant_sel (
`ifdef MEM_ARB_RR_EN
        .clk    (clk),
        .rst_n  (rst_n),
`endif
        .en     (run),
        .if_req (bus.if_req),
        .dm_req (bus.dm_req),
        .if_gnt (if_gnt),
        .dm_gnt (dm_gnt)
    );

    // Boot FSM: a word is written on every valid beat; the stream ends on last or when full.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = done_q;
        err_d   = err_q;
        boot_wr = 1'b0;
        if (state_q == ST_BOOT && bus.boot_valid) begin
            boot_wr = 1'b1;
            count_d = count_q + WA_W'(1);
            if (bus.boot_last) begin
                state_d = ST_RUN;
                done_d  = 1'b1;
            end else if (count_q == LAST_IDX) begin
                state_d = ST_RUN;
                done_d  = 1'b1;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Stage 0: memory command and grant tag for the following read-return cycle.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        gnt_tag_d     = G_NONE;
        if (boot_wr) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = '1;
            bus.mem_addr  = count_q;
            bus.mem_wdata = bus.boot_data;
        end else if (dm_gnt) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.dm_addr[ADDR_W-1:WORD_LSB];
            if (bus.dm_we) begin
                bus.mem_we    = bus.dm_be;
                bus.mem_wdata = bus.dm_wdata;
            end else begin
                gnt_tag_d = G_DM;
            end
        end else if (if_gnt) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.if_addr[ADDR_W-1:WORD_LSB];
            gnt_tag_d    = G_IF;
        end
    end

    always_comb begin
        bus.boot_ready = (state_q == ST_BOOT);
        bus.boot_done  = done_q;
        bus.boot_err   = err_q;
        bus.cpu_stall  = run ? (bus.if_req && !if_gnt) : 1'b1;
        bus.if_gnt     = if_gnt;
        bus.dm_gnt     = dm_gnt;
    end

    // Stage 1: read data returns from the array; route it by tag and hold it afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_tag_p1  <= G_NONE;
            if_rdata_p1 <= '0;
            dm_rdata_p1 <= '0;
        end else begin
            gnt_tag_p1 <= gnt_tag_d;
            if (gnt_tag_p1 == G_IF) if_rdata_p1 <= bus.mem_rdata;
            if (gnt_tag_p1 == G_DM) dm_rdata_p1 <= bus.mem_rdata;
        end
    end

    always_comb begin
        bus.if_rvalid = (gnt_tag_p1 == G_IF);
        bus.dm_rvalid = (gnt_tag_p1 == G_DM);
        bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : if_rdata_p1;
        bus.dm_rdata  = bus.dm_rvalid ? bus.mem_rdata : dm_rdata_p1;
    end

endmodule

// File: tb/tb_mem_boot_arbiter.sv
// Scoreboard bench for mem_boot_arbiter (BOOT_WORDS=4 build); honours MEM_ARB_RR_EN.
module tb_mem_boot_arbiter;
    import mem_arb_pkg::*;

`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_boot_arbiter_if #(.ADDR_W(12)) bus ();

    mem_boot_arbiter #(.ADDR_W(12), .BOOT_WORDS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory array model: byte-enabled write, 1-cycle synchronous read.
    logic [31:0] mem [0:1023];
    logic [31:0] mem_w;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we == 4'h0) begin
                bus.mem_rdata <= mem[bus.mem_addr];
            end else begin
                mem_w = mem[bus.mem_addr];
                for (int b = 0; b < 4; b++)
                    if (bus.mem_we[b]) mem_w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
                mem[bus.mem_addr] <= mem_w;
            end
        end
    end

    int n_chk = 0;
    int n_pass = 0;
    logic [45:0] wr_q [$];
    logic [31:0] if_q [$];
    logic [31:0] dm_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_chk++;
        $display("FAIL %s: unexpected output 0x%0h, want none", name, act);
    endtask

    // Monitor: pops scoreboard entries whenever the DUT presents a write or read return.
    logic [45:0] mon_w;
    logic [31:0] mon_d;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_en && bus.mem_we != 4'h0) begin
                if (wr_q.size() == 0) unexpected("mem_write", 64'({bus.mem_addr, bus.mem_we, bus.mem_wdata}));
                else begin
                    mon_w = wr_q.pop_front();
                    chk("mem_write", 64'({bus.mem_addr, bus.mem_we, bus.mem_wdata}), 64'(mon_w));
                end
            end
            if (bus.if_rvalid) begin
                if (if_q.size() == 0) unexpected("if_rdata", 64'(bus.if_rdata));
                else begin
                    mon_d = if_q.pop_front();
                    chk("if_rdata", 64'(bus.if_rdata), 64'(mon_d));
                end
            end
            if (bus.dm_rvalid) begin
                if (dm_q.size() == 0) unexpected("dm_rdata", 64'(bus.dm_rdata));
                else begin
                    mon_d = dm_q.pop_front();
                    chk("dm_rdata", 64'(bus.dm_rdata), 64'(mon_d));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.boot_valid = 1'b0;
        bus.boot_last  = 1'b0;
        bus.if_req     = 1'b0;
        bus.dm_req     = 1'b0;
        bus.dm_we      = 1'b0;
        bus.dm_be      = 4'h0;
    endtask

    task automatic check_reset_outs(input string t);
        chk({t, "_boot_ready"}, 64'(bus.boot_ready), 64'(1));
        chk({t, "_cpu_stall"},  64'(bus.cpu_stall),  64'(1));
        chk({t, "_done_err"},   64'({bus.boot_done, bus.boot_err}), 64'(0));
        chk({t, "_gnts"},       64'({bus.if_gnt, bus.dm_gnt}), 64'(0));
        chk({t, "_rvalids"},    64'({bus.if_rvalid, bus.dm_rvalid}), 64'(0));
        chk({t, "_rdatas"},     64'({bus.if_rdata, bus.dm_rdata}), 64'(0));
        chk({t, "_mem_cmd"},    64'({bus.mem_en, bus.mem_we, bus.mem_addr}), 64'(0));
        chk({t, "_mem_wdata"},  64'(bus.mem_wdata), 64'(0));
    endtask

    task automatic boot_word(input logic [31:0] d, input logic last, input logic [9:0] a);
        tick();
        bus.boot_valid = 1'b1;
        bus.boot_data  = d;
        bus.boot_last  = last;
        wr_q.push_back({a, 4'hF, d});
        @(negedge clk);
        chk("boot_ready", 64'(bus.boot_ready), 64'(1));
        chk("boot_stall", 64'(bus.cpu_stall), 64'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    logic exp_dm;

    initial begin
        idle();
        bus.boot_data = '0;
        bus.if_addr   = '0;
        bus.dm_addr   = '0;
        bus.dm_wdata  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outs("rst0");
        tick();
        rst_n = 1'b1;

        // Overflowing boot: four words without last
        boot_word(32'h11111111, 1'b0, 10'd0);
        boot_word(32'h22222222, 1'b0, 10'd1);
        boot_word(32'h33333333, 1'b0, 10'd2);
        boot_word(32'h44444444, 1'b0, 10'd3);
        chk("t2_done_early", 64'(bus.boot_done), 64'(0));
        tick();
        idle();
        bus.boot_valid = 1'b1;
        bus.boot_data  = 32'h55555555;
        @(negedge clk);
        chk("t2_done_err", 64'({bus.boot_done, bus.boot_err}), 64'(2'b11));
        chk("t2_ready", 64'(bus.boot_ready), 64'(0));
        chk("t2_5th_mem_en", 64'(bus.mem_en), 64'(0));
        chk("t2_stall", 64'(bus.cpu_stall), 64'(0));
        tick();
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outs("rst1");
        tick();
        rst_n = 1'b1;

        // Normal boot of three words
        boot_word(32'h00000013, 1'b0, 10'd0);
        boot_word(32'h00100093, 1'b0, 10'd1);
        boot_word(32'hDEADBEEF, 1'b1, 10'd2);
        tick();
        idle();
        @(negedge clk);
        chk("t1_done_err", 64'({bus.boot_done, bus.boot_err}), 64'(2'b10));
        chk("t1_stall", 64'(bus.cpu_stall), 64'(0));
        chk("t1_ready", 64'(bus.boot_ready), 64'(0));

        // Fetch only
        tick();
        bus.if_req  = 1'b1;
        bus.if_addr = 12'h008;
        if_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        chk("t3_gnts", 64'({bus.if_gnt, bus.dm_gnt}), 64'(2'b10));
        chk("t3_stall", 64'(bus.cpu_stall), 64'(0));
        chk("t3_mem_cmd", 64'({bus.mem_en, bus.mem_we, bus.mem_addr}), 64'({1'b1, 4'h0, 10'd2}));
        tick();
        idle();
        @(negedge clk);

        // Contention: data port wins, fetch follows
        tick();
        bus.if_req  = 1'b1;
        bus.if_addr = 12'h000;
        bus.dm_req  = 1'b1;
        bus.dm_addr = 12'h004;
        dm_q.push_back(32'h00100093);
        @(negedge clk);
        chk("t4_gnts", 64'({bus.if_gnt, bus.dm_gnt}), 64'(2'b01));
        chk("t4_stall", 64'(bus.cpu_stall), 64'(1));
        chk("t4_mem_addr", 64'(bus.mem_addr), 64'(1));
        tick();
        bus.dm_req = 1'b0;
        if_q.push_back(32'h00000013);
        @(negedge clk);
        chk("t4_gnts2", 64'({bus.if_gnt, bus.dm_gnt}), 64'(2'b10));
        chk("t4_stall2", 64'(bus.cpu_stall), 64'(0));
        chk("t4_if_rvalid", 64'(bus.if_rvalid), 64'(0));
        chk("t4_if_hold", 64'(bus.if_rdata), 64'(32'hDEADBEEF));
        tick();
        idle();
        @(negedge clk);

        // Byte store, load back, then an empty-enable store
        tick();
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_be    = 4'b0010;
        bus.dm_addr  = 12'h000;
        bus.dm_wdata = 32'h0000AB00;
        wr_q.push_back({10'd0, 4'b0010, 32'h0000AB00});
        @(negedge clk);
        chk("t5_st_gnt", 64'(bus.dm_gnt), 64'(1));
        tick();
        bus.dm_we = 1'b0;
        dm_q.push_back(32'h0000AB13);
        @(negedge clk);
        chk("t5_ld_gnt", 64'(bus.dm_gnt), 64'(1));
        tick();
        bus.dm_we    = 1'b1;
        bus.dm_be    = 4'h0;
        bus.dm_addr  = 12'h004;
        bus.dm_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("t5_be0_gnt", 64'(bus.dm_gnt), 64'(1));
        chk("t5_be0_cmd", 64'({bus.mem_en, bus.mem_we}), 64'({1'b1, 4'h0}));
        tick();
        bus.dm_we = 1'b0;
        dm_q.push_back(32'h00100093);
        @(negedge clk);
        chk("t5_be0_no_rvalid", 64'(bus.dm_rvalid), 64'(0));
        tick();
        idle();
        @(negedge clk);

        // Sustained contention, preceded by a lone fetch so fetch was granted last
        tick();
        bus.if_req  = 1'b1;
        bus.if_addr = 12'h008;
        if_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        chk("t6_pre_gnt", 64'(bus.if_gnt), 64'(1));
        for (int i = 0; i < 6; i++) begin
            tick();
            bus.if_req  = 1'b1;
            bus.if_addr = 12'h008;
            bus.dm_req  = 1'b1;
            bus.dm_we   = 1'b0;
            bus.dm_addr = 12'h004;
            exp_dm = RR_EN ? (i % 2 == 0) : 1'b1;
            if (exp_dm) dm_q.push_back(32'h00100093);
            else        if_q.push_back(32'hDEADBEEF);
            @(negedge clk);
            chk($sformatf("t6_gnts_%0d", i), 64'({bus.if_gnt, bus.dm_gnt}), 64'({!exp_dm, exp_dm}));
            chk($sformatf("t6_stall_%0d", i), 64'(bus.cpu_stall), 64'(exp_dm));
        end
        tick();
        rst_n = 1'b0;
        wr_q.delete();
        if_q.delete();
        dm_q.delete();
        @(negedge clk);
        check_reset_outs("rst2");
        tick();
        idle();
        rst_n = 1'b1;
        boot_word(32'hCAFEF00D, 1'b1, 10'd0);
        tick();
        idle();
        @(negedge clk);
        chk("t6_reboot_done", 64'(bus.boot_done), 64'(1));

        repeat (2) tick();
        chk("wr_q_drained", 64'(wr_q.size()), 64'(0));
        chk("if_q_drained", 64'(if_q.size()), 64'(0));
        chk("dm_q_drained", 64'(dm_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
